// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with a show-ahead output FIFO and one-cycle
// error pulses (frame, parity, overrun). The line is synchronised, the start
// bit is confirmed at mid-bit, and every later bit is sampled at mid-bit.
// Optional parity bit: define UART_RX_PARITY_EN.
//
// state   | meaning
// IDLE    | line idle, waiting for rxs low
// START   | half-bit wait, confirm start bit at its middle
// DATA    | sample DATA_WIDTH data bits, LSB first
// PARITY  | sample the parity bit (UART_RX_PARITY_EN only)
// STOP    | sample STOP_BITS stop bits, commit on the last one
// RECOVER | a stop bit was low, wait for the line to return high
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun_err
);

  localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
  localparam int TW = $clog2(PULSE_WIDTH) + 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] T_FULL    = TW'(PULSE_WIDTH - 1);
  localparam logic [TW-1:0] T_HALF    = TW'(PULSE_WIDTH / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS == 2);
  localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_RECOVER
  } state_t;

  state_t state, state_nx;

  logic                  rx_meta, rxs;
  logic [TW-1:0]         timer;
  logic                  tick;
  logic [BW-1:0]         bit_idx;
  logic                  stop_idx;
  logic [DATA_WIDTH-1:0] data_sr;
  logic                  par_bit, par_exp, parity_ok;

  logic load_half, load_full, shift_en, par_en, stop_next, stop_bad, commit;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  push, pop, space;

  assign tick = (timer == '0);

  // two-flop synchroniser, idles high out of reset
  always_ff @(posedge clk or posedge rst)
    if (rst) {rxs, rx_meta} <= 2'b11;
    else     {rxs, rx_meta} <= {rx_meta, rx};

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= state_nx;

  // next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (!rxs) state_nx = S_START;
      S_START:   if (tick) state_nx = rxs ? S_IDLE : S_DATA;
      S_DATA:
        if (tick && bit_idx == LAST_BIT)
`ifdef UART_RX_PARITY_EN
          state_nx = S_PARITY;
`else
          state_nx = S_STOP;
`endif
      S_PARITY:  if (tick) state_nx = S_STOP;
      S_STOP:
        if (tick) begin
          if (!rxs)                       state_nx = S_RECOVER;
          else if (stop_idx == STOP_LAST) state_nx = S_IDLE;
        end
      S_RECOVER: if (rxs) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // per-state control strobes
  always_comb begin
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    stop_next = 1'b0;
    stop_bad  = 1'b0;
    commit    = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:   load_half = !rxs;
      S_START:  load_full = tick;
      S_DATA: begin
        load_full = tick;
        shift_en  = tick;
      end
      S_PARITY: begin
        load_full = tick;
        par_en    = tick;
      end
      S_STOP: begin
        load_full = tick;
        stop_bad  = tick && !rxs;
        commit    = tick && rxs && (stop_idx == STOP_LAST);
        stop_next = tick && rxs && (stop_idx != STOP_LAST);
      end
      default: ;
    endcase
  end

  // bit timer, bit counters and data shift register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      timer    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      data_sr  <= '0;
    end else begin
      if (load_half)      timer <= T_HALF;
      else if (load_full) timer <= T_FULL;
      else if (!tick)     timer <= timer - 1'b1;

      if (shift_en)             bit_idx <= bit_idx + 1'b1;
      else if (state != S_DATA) bit_idx <= '0;

      if (stop_next)            stop_idx <= 1'b1;
      else if (state != S_STOP) stop_idx <= 1'b0;

      if (shift_en) data_sr <= {rxs, data_sr[DATA_WIDTH-1:1]};
    end

  assign par_exp   = (^data_sr) ^ 1'(PARITY_ODD);
  assign parity_ok = (par_bit == par_exp);

`ifdef UART_RX_PARITY_EN
  // parity bit captured at its mid-bit
  always_ff @(posedge clk or posedge rst)
    if (rst)         par_bit <= 1'b0;
    else if (par_en) par_bit <= rxs;

  // parity mismatch pulse at commit time
  always_ff @(posedge clk or posedge rst)
    if (rst) parity_err <= 1'b0;
    else     parity_err <= commit && !parity_ok;
`else
  // no parity bit on the line, so the word always checks out
  assign par_bit    = par_exp;
  assign parity_err = 1'b0;
`endif

  // a simultaneous pop frees a slot for this cycle's push
  assign pop   = m_valid && m_ready;
  assign space = (fifo_count < DEPTH) || pop;
  assign push  = commit && parity_ok && space;

  // frame and overrun pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= stop_bad;
      overrun_err <= commit && parity_ok && !space;
    end

  // FIFO storage, cleared so the head reads 0 out of reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= data_sr;
    end

  // FIFO pointers and occupancy; pointers wrap by width
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end

  assign m_valid = (fifo_count != '0);
  assign m_data  = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 10 clocks per bit, 8N1 (8E1 when
// UART_RX_PARITY_EN is defined), FIFO depth 4.
module tb_uart_rx_fifo;

  localparam int PW = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [2:0] fifo_count;
  logic       busy, frame_err, parity_err, overrun_err;

  int checks = 0;
  int passes = 0;
  int n_frame = 0, n_par = 0, n_ovr = 0, n_valid = 0;
  int exp_n = 0;
  logic [7:0] got_q[$];
  logic [7:0] v99;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx_fifo #(
    .DATA_WIDTH(8), .BAUD_RATE(100_000), .CLK_FREQ(1_000_000),
    .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_count(fifo_count), .busy(busy),
    .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  // observe pulses and accepted words away from the active edge
  always @(negedge clk) begin
    if (frame_err)   n_frame++;
    if (parity_err)  n_par++;
    if (overrun_err) n_ovr++;
    if (m_valid)     n_valid++;
    if (m_valid && m_ready) got_q.push_back(m_data);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(logic b);
    rx = b;
    tick(PW);
  endtask

  task automatic send_frame(logic [7:0] d, logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop_v);
    rx = 1'b1;
  endtask

  function automatic logic [7:0] last_got();
    if (got_q.size() == 0) return 8'hxx;
    return got_q[got_q.size()-1];
  endfunction

  initial begin
    rst = 1'b1; rx = 1'b1; m_ready = 1'b0;
    tick(3);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {frame_err, parity_err, overrun_err}, 0);
    rst = 1'b0;
    tick(5);

    // single word, consumer always ready
    m_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    tick(20);
    exp_n = 1;
    check("t1_words", got_q.size(), exp_n);
    check("t1_data", last_got(), 8'hA5);
    check("t1_valid_cycles", n_valid, 1);
    check("t1_errs", n_frame + n_par + n_ovr, 0);
    check("t1_busy", busy, 0);
    check("t1_count", fifo_count, 0);

    // short low glitch is not a start bit
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(30);
    check("t2_busy", busy, 0);
    check("t2_count", fifo_count, 0);
    check("t2_words", got_q.size(), exp_n);
    check("t2_errs", n_frame + n_par + n_ovr, 0);

    // fill with consumer stalled, fifth word overruns
    m_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1);
    check("t3_count_full", fifo_count, 4);
    check("t3_no_ovr_yet", n_ovr, 0);
    send_frame(8'h05, 1'b1);
    tick(10);
    check("t3_count_after", fifo_count, 4);
    check("t3_ovr", n_ovr, 1);
    check("t3_head_stable", m_data, 8'h01);
    check("t3_valid", m_valid, 1);
    m_ready = 1'b1;
    tick(10);
    check("t3_words", got_q.size(), exp_n + 4);
    for (int k = 1; k <= 4; k++) check("t3_order", got_q[exp_n + k - 1], 8'(k));
    exp_n += 4;
    check("t3_drained", fifo_count, 0);

    // bad stop bit followed by a long break
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    tick(30 * PW);
    check("t4_frame_err", n_frame, 1);
    check("t4_busy_break", busy, 1);
    check("t4_no_push", got_q.size(), exp_n);
    rx = 1'b1;
    tick(2 * PW);
    check("t4_idle", busy, 0);
    send_frame(8'h7E, 1'b1);
    tick(20);
    exp_n++;
    check("t4_words", got_q.size(), exp_n);
    check("t4_data", last_got(), 8'h7E);
    check("t4_frame_err_once", n_frame, 1);

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    tick(20);
    check("t5_par_err", n_par, 1);
    check("t5_no_push", got_q.size(), exp_n);
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    tick(20);
    exp_n++;
    check("t5_words", got_q.size(), exp_n);
    check("t5_data", last_got(), 8'h07);
    check("t5_par_err_once", n_par, 1);
`else
    check("t5_par_never", n_par, 0);
`endif

    // reset mid-frame with two words queued
    m_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(5);
    check("t6_count_pre", fifo_count, 2);
    v99 = 8'h99;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(v99[i]);
    rx = v99[4];
    tick(5);
    check("t6_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check("t6_valid_async", m_valid, 0);
    check("t6_count_async", fifo_count, 0);
    check("t6_busy_async", busy, 0);
    tick(2);
    rx = 1'b1;
    rst = 1'b0;
    tick(20);
    m_ready = 1'b1;
    send_frame(8'h55, 1'b1);
    tick(20);
    exp_n++;
    check("t6_words", got_q.size(), exp_n);
    check("t6_data", last_got(), 8'h55);
    check("t6_count", fifo_count, 0);
    check("t6_frame_err", n_frame, 1);
    check("t6_ovr", n_ovr, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
